// File: rtl/cmp_pkg.sv
// Shared definitions for the compare arbiter: RV32I branch funct3 op codes,
// FSM state type and default operand width.
package cmp_pkg;

    localparam int CMP_WIDTH_DEFAULT = 32;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : cmp_pkg

// File: rtl/cmp_core.sv
// Stateless comparator shared by both requesters. It derives EQ, LT and LTU
// from a single (WIDTH+1)-bit subtraction, and it flags ops 010/011 as illegal.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             r_o,
    output logic             err_o
);

    logic [WIDTH:0] diff;
    logic           eq;
    logic           lt;
    logic           ltu;
    logic           a_sign;
    logic           b_sign;

    assign diff   = {1'b0, a_i} - {1'b0, b_i};
    assign a_sign = a_i[WIDTH-1];
    assign b_sign = b_i[WIDTH-1];
    assign eq     = (diff[WIDTH-1:0] == '0);
    assign ltu    = diff[WIDTH];
    // With differing signs the negative operand is smaller. With equal signs
    // the subtraction cannot overflow, so its sign bit decides.
    assign lt     = (a_sign & ~b_sign) | (~eq & diff[WIDTH-1] & (~b_sign | a_sign));

    always_comb begin
        // NOTE: give every combinational output a default first so that no path leaves it unassigned (no latch).
        r_o   = 1'b0;
        err_o = 1'b0;
        case (op_i)
            CMP_EQ:  r_o = eq;
            CMP_NE:  r_o = ~eq;
            CMP_LT:  r_o = lt;
            CMP_GE:  r_o = ~lt;
            CMP_LTU: r_o = ltu;
            CMP_GEU: r_o = ~ltu;
            default: err_o = 1'b1;
        endcase
    end

endmodule : cmp_core

// File: rtl/compare_arbiter.sv
// Two-requester arbiter in front of one shared cmp_core. It uses an IDLE/EXEC/RESP FSM.
// When CMP_ARB_RR_EN is defined, simultaneous requests are granted round-robin.
module compare_arbiter
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    output logic             resp_valid,
    output logic             resp_id,
    output logic             resp_r,
    output logic             resp_err,
    input  logic             resp_ready
);

    state_e           state_q, state_d;
    logic             grant_id;
    logic             accept;
    logic [1:0]       ready_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             id_q;
    logic             resp_id_q, resp_r_q, resp_err_q;
    logic             core_r, core_err;

`ifdef CMP_ARB_RR_EN
    logic ptr_q;

    // The pointer favours one requester on a tie and then flips to the loser.
    assign grant_id = (&req_valid) ? ptr_q : ~req_valid[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers update with non-blocking assignments only.
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= ~grant_id;
        end
    end
`else
    assign grant_id = ~req_valid[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 2'b00;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    accept  = 1'b1;
                    ready_d = grant_id ? 2'b10 : 2'b01;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Gate the grant with rst_n so that req_ready drops as soon as reset is asserted.
    assign req_ready = ready_d & {2{rst_n}};

    // NOTE: operand capture registers need no reset; they are only read after a capture has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= grant_id ? req_a1 : req_a0;
            b_q  <= grant_id ? req_b1 : req_b0;
            op_q <= grant_id ? req_op1 : req_op0;
            id_q <= grant_id;
        end
    end

    cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .r_o   (core_r),
        .err_o (core_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_id_q  <= 1'b0;
            resp_r_q   <= 1'b0;
            resp_err_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            resp_id_q  <= id_q;
            resp_r_q   <= core_r;
            resp_err_q <= core_err;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = resp_id_q;
    assign resp_r     = resp_r_q;
    assign resp_err   = resp_err_q;

endmodule : compare_arbiter

// File: tb/tb_compare_arbiter.sv
// Directed, table-driven bench for compare_arbiter. It covers reset, arbitration
// (follows CMP_ARB_RR_EN), a response stall and a reset while a request is in flight.
module tb_compare_arbiter;
    import cmp_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]   req_op0, req_op1;
    logic         resp_valid, resp_id, resp_r, resp_err;
    logic         resp_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         exp_r;
        logic         exp_err;
    } vec_t;

    vec_t vecs[14];

    compare_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_r     (resp_r),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before it");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] op);
        req_valid = id ? 2'b10 : 2'b01;
        if (id) begin
            req_a1 = a; req_b1 = b; req_op1 = op;
        end else begin
            req_a0 = a; req_b0 = b; req_op0 = op;
        end
    endtask

    // Toggling op bit 0 swaps EQ/NE, LT/GE and LTU/GEU, so a late change would flip a legal result.
    task automatic scramble();
        req_a0 = ~req_a0; req_b0 = ~req_b0; req_op0 = req_op0 ^ 3'b001;
        req_a1 = ~req_a1; req_b1 = ~req_b1; req_op1 = req_op1 ^ 3'b001;
    endtask

    // Called on a negedge while the FSM is in IDLE. Returns on the negedge after the handshake.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive_req(v.id, v.a, v.b, v.op);
        #1;
        check({tag, " req_ready"}, 32'(req_ready), v.id ? 32'd2 : 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        scramble();
        #1;
        check({tag, " exec resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " exec req_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_id"}, 32'(resp_id), 32'(v.id));
        check({tag, " resp_r"}, 32'(resp_r), 32'(v.exp_r));
        check({tag, " resp_err"}, 32'(resp_err), 32'(v.exp_err));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " idle resp_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic exp_id;

        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, CMP_LT,  1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, CMP_LTU, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, CMP_GEU, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, CMP_EQ,  1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0005, 32'h0000_0005, 3'b010,  1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0005, 32'h0000_0009, 3'b011,  1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0005, 32'h0000_0006, CMP_NE,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, CMP_GE,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h7FFF_FFFF, 32'h8000_0000, CMP_LT,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, CMP_LTU, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0001, 32'h0000_0002, CMP_EQ,  1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0005, 32'h0000_0005, CMP_GE,  1'b1, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0003, 32'h0000_0003, CMP_LT,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, CMP_LT,  1'b1, 1'b0};

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 1'b0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_op0 = CMP_EQ; req_op1 = CMP_EQ;

        // Reset state, with both requesters asserting valid while reset is held.
        @(negedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_id", 32'(resp_id), 32'd0);
        check("reset resp_r", 32'(resp_r), 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;

        // Both requesters are valid for four back-to-back requests. Requester 0 (EQ 1,1) returns 1 and requester 1 (NE 1,1) returns 0.
        @(negedge clk);
        req_valid = 2'b11;
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = CMP_EQ;
        req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = CMP_NE;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef CMP_ARB_RR_EN
            exp_id = (k % 2) == 1;
`else
            exp_id = 1'b0;
`endif
            #1;
            check($sformatf("arb%0d req_ready", k), 32'(req_ready), exp_id ? 32'd2 : 32'd1);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("arb%0d resp_id", k), 32'(resp_id), 32'(exp_id));
            check($sformatf("arb%0d resp_r", k), 32'(resp_r), exp_id ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        req_valid  = 2'b00;
        resp_ready = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Stall: resp_ready stays low for 5 cycles in RESP while both requesters are valid.
        @(negedge clk);
        drive_req(1'b0, 32'd9, 32'd3, CMP_GE);
        #1;
        check("stall req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b11;
        scramble();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d resp_valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("stall%0d resp_r", c), 32'(resp_r), 32'd1);
            check($sformatf("stall%0d resp_id", c), 32'(resp_id), 32'd0);
            check($sformatf("stall%0d resp_err", c), 32'(resp_err), 32'd0);
            check($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
            req_a0 = req_a0 + 32'd17;
        end
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("stall release resp_valid", 32'(resp_valid), 32'd0);

        // Reset pulsed during EXEC: the in-flight request is dropped.
        @(negedge clk);
        drive_req(1'b1, 32'd0, 32'd1, CMP_LTU);
        #1;
        check("rstexec req_ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        check("rstexec resp_valid", 32'(resp_valid), 32'd0);
        check("rstexec req_ready", 32'(req_ready), 32'd0);
        check("rstexec resp_r", 32'(resp_r), 32'd0);
        check("rstexec resp_id", 32'(resp_id), 32'd0);
        check("rstexec resp_err", 32'(resp_err), 32'd0);
        req_valid = 2'b00;
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("postrst%0d resp_valid", c), 32'(resp_valid), 32'd0);
        end
        run_vec('{1'b1, 32'h0000_0000, 32'h0000_0001, CMP_LTU, 1'b1, 1'b0}, "postrst vec");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_compare_arbiter
